cp0_ctrl: RTL
=============

Name: cp0_ctrl

Overview:
- Parametrised CP0 controller for the MIPS core. Holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config.
- Takes the writeback-stage exception/ERET commit and produces the interrupt request and the redirect target to the PC logic.
- Adds over the previous generation: a Count prescaler, a configurable hardware-interrupt width, the EXL-nesting rule, a BEV-selected vector, ERET handling and a defined same-cycle priority.

Parameters:
- HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2].
- COUNT_DIV, 2, core cycles per Count increment (>=1).
- PRID_VAL, 32'h004C0102, read-only PRId value.
- CONFIG_VAL, 32'h00008000, read-only Config value.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number.
- raddr_i  in  5  MFC0 register number.
- data_i  in  32  MTC0 data.
- data_o  out  32  MFC0 read data, combinational.
- int_i  in  HW_INT_NUM  hardware interrupt lines.
- exc_valid_i  in  1  exception commit.
- exc_code_i  in  5  ExcCode.
- exc_pc_i  in  32  PC of the faulting instruction.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- exc_badvaddr_i  in  32  faulting address.
- eret_i  in  1  ERET commit.
- int_req_o  out  1  interrupt pending and enabled.
- flush_o  out  1  exc_valid_i | eret_i.
- target_o  out  32  redirect PC.
- status_o, cause_o, epc_o  out  32 each  live register values.

Behaviour:
- Reset values (cycle after rst=1):
  - count, compare, cause, epc, badvaddr = 0.
  - status = 32'h00400000 (BEV=1, EXL=0, IE=0).
  - Prescaler = 0.
  - int_req_o = 0; flush_o = 0 unless inputs are active.
  - Reset mid-exception discards all pending updates.
- Prescaler counts 0..COUNT_DIV-1. On wrap, Count += 1 (mod 2^32). COUNT_DIV=1 gives an increment every cycle.
- MTC0 Count loads data_i and clears the prescaler. The next increment occurs COUNT_DIV cycles later.
- Timer: on the cycle Count becomes equal to Compare, Cause.TI (bit 30) <= 1. TI stays set until an MTC0 to Compare, which clears it. If a Compare write and a match happen in the same cycle, the write wins (TI=0).
- Cause.IP[7:2]:
  - Sampled from int_i every cycle, zero-extended above HW_INT_NUM.
  - IP7 = int_i[5] | TI (the int_i[5] term applies only if HW_INT_NUM=6).
- MTC0 writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC and Compare: full width. Count: full width.
  - All other bits and registers, including BadVAddr, are read-only; writes to them are ignored.
- Exception commit (exc_valid_i=1):
  - If Status.EXL=0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD (31) <= exc_bd_i.
  - If Status.EXL=1: EPC and BD are held.
  - Always: EXL <= 1, Cause.ExcCode[6:2] <= exc_code_i.
  - ExcCode 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr_i.
- ERET: EXL <= 0.
- Priority within a cycle:
  - exc_valid_i > eret_i.
  - exc_valid_i suppresses any same-cycle MTC0.
  - MTC0 together with eret_i: the MTC0 applies, then EXL is cleared.
- target_o, combinational:
  - eret_i: current epc.
  - Otherwise: BEV ? 32'hBFC00380 : 32'h80000180.
- int_req_o = IE & ~EXL & |(Cause.IP[7:0] & Status.IM[7:0]), computed from registered state. Latency is one cycle from the int_i edge.
- data_o: selected register by raddr_i; unmapped addresses return 0. Reads see pre-write values (no write-through).

Optional Feature:
- CP0_TIMER_INT_EN.
  - Defined: timer sets TI/IP7 as above.
  - Undefined: Compare remains readable/writable and Count still runs, but TI is constant 0 and IP7 = int_i[5] only.

Decomposition:
- Shared defines header holds:
  - CP0 register numbers (Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16, BadVAddr 8).
  - ExcCode constants.
  - Status/Cause bit positions.
  - Both vector addresses.
- Sub-module cp0_timer: prescaler, Count, Compare and TI. Its interface is the MTC0 write strobe, data and address, plus a ti_o output.

Test Plan:
- COUNT_DIV=2, reset, run 10 cycles -> count=5. MTC0 Count=32'hFFFFFFFF, then 2 cycles -> count=0 (wrap).
- Compare=3, IE=1, IM7=1, EXL=0 -> TI=1 and int_req_o=1 one cycle after Count==3. MTC0 Compare -> TI=0, int_req_o=0.
- exc_valid_i, code 4, pc=32'h80001004, bd=1, badvaddr=32'h13 -> epc=32'h80001000, BD=1, ExcCode=4, BadVAddr=32'h13, EXL=1, target_o=32'hBFC00380.
- Second exception with EXL=1, pc=32'h80002000 -> epc unchanged (32'h80001000), ExcCode updated.
- eret_i with epc=32'h80001000 -> target_o=32'h80001000, next-cycle EXL=0. Same cycle as exc_valid_i -> exception wins, EXL stays 1.
- exc_valid_i and MTC0 Status=32'h0000FF01 in the same cycle -> Status.IM is unchanged, only EXL is set.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, Status/Cause
// bit positions, exception vectors and the packed register layouts.
package cp0_pkg;

  // CP0 register numbers as seen by MTC0/MFC0
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status / Cause bit positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  // General exception vectors (BEV=1 / BEV=0)
  localparam logic [31:0] VEC_BEV1 = 32'hBFC0_0380;
  localparam logic [31:0] VEC_BEV0 = 32'h8000_0180;

  // Writable Status state (BEV is hard-wired to 1)
  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // Stored Cause state; TI lives in the timer, IP7 is merged on read
  typedef struct packed {
    logic       bd;
    logic [5:0] ip_hw;
    logic [1:0] ip_sw;
    logic [4:0] exc_code;
  } cause_t;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: Count prescaler, Count, Compare and the sticky timer
// interrupt flag TI. The timer interrupt is generated only when the
// macro CP0_TIMER_INT_EN is defined; otherwise ti_o is constant 0 while
// Count and Compare keep working.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          presc_wrap;
  logic          wr_count;
  logic          wr_compare;

  assign presc_wrap = (presc == PW'(COUNT_DIV - 1));
  assign wr_count   = we && (waddr == REG_COUNT);
  assign wr_compare = we && (waddr == REG_COMPARE);

  // Prescaler, Count and Compare; a Count write restarts the prescaler
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
    end else begin
      if (wr_count) begin
        count <= data;
        presc <= '0;
      end else if (presc_wrap) begin
        count <= count + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (wr_compare) compare <= data;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic count_upd;
  logic ti;

  // TI rises once Count has just changed to the Compare value; a Compare
  // write clears it and wins over a same-cycle match
  always_ff @(posedge clk) begin
    if (rst) begin
      count_upd <= 1'b0;
      ti        <= 1'b0;
    end else begin
      count_upd <= wr_count | presc_wrap;
      if (wr_compare) begin
        ti <= 1'b0;
      end else if (count_upd && (count == compare)) begin
        ti <= 1'b1;
      end
    end
  end

  assign ti_o = ti;
`else
  assign ti_o = 1'b0;
`endif

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 controller top: Status, Cause, EPC, BadVAddr plus read-only PRId and
// Config, exception/ERET commit handling, interrupt request and redirect
// target. The optional timer interrupt is controlled by CP0_TIMER_INT_EN
// (handled inside cp0_timer).
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic                  int_req_o,
  output logic                  flush_o,
  output logic [31:0]           target_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  status_t     status;
  cause_t      cause;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        mtc0;
  logic [7:0]  ip;

  // An exception commit suppresses any MTC0 in the same cycle
  assign mtc0 = we_i & ~exc_valid_i;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .we      (mtc0),
    .waddr   (waddr_i),
    .data    (data_i),
    .count   (count),
    .compare (compare),
    .ti_o    (ti)
  );

  // Status, Cause, EPC and BadVAddr updates: exception > MTC0 > ERET clear
  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= '0;
      cause    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      cause.ip_hw <= 6'(int_i);
      if (exc_valid_i) begin
        // A nested exception keeps the original EPC and BD
        if (!status.exl) begin
          epc      <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
          cause.bd <= exc_bd_i;
        end
        status.exl     <= 1'b1;
        cause.exc_code <= exc_code_i;
        if (is_addr_exc(exc_code_i)) badvaddr <= exc_badvaddr_i;
      end else begin
        if (mtc0) begin
          case (waddr_i)
            REG_STATUS: begin
              status.im  <= data_i[STATUS_IM_LO +: 8];
              status.exl <= data_i[STATUS_EXL];
              status.ie  <= data_i[STATUS_IE];
            end
            REG_CAUSE: cause.ip_sw <= data_i[CAUSE_IP_LO +: 2];
            REG_EPC:   epc         <= data_i;
            default:   ;
          endcase
        end
        // Placed after the MTC0 so ERET's EXL clear overrides a Status write
        if (eret_i) status.exl <= 1'b0;
      end
    end
  end

  assign ip       = {cause.ip_hw[5] | ti, cause.ip_hw[4:0], cause.ip_sw};
  assign status_o = {9'b0, 1'b1, 6'b0, status.im, 6'b0, status.exl, status.ie};
  assign cause_o  = {cause.bd, ti, 14'b0, ip, 1'b0, cause.exc_code, 2'b0};
  assign epc_o    = epc;

  assign int_req_o = status.ie & ~status.exl & (|(ip & status.im));
  assign flush_o   = exc_valid_i | eret_i;
  assign target_o  = (eret_i && !exc_valid_i) ? epc
                   : (status_o[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0);

  // MFC0 read mux; shows pre-write register contents
  always_comb begin
    // NOTE: default assignment first so no path leaves data_o unassigned
    // and no latch is inferred.
    data_o = '0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr;
      REG_COUNT:    data_o = count;
      REG_COMPARE:  data_o = compare;
      REG_STATUS:   data_o = status_o;
      REG_CAUSE:    data_o = cause_o;
      REG_EPC:      data_o = epc;
      REG_PRID:     data_o = PRID_VAL;
      REG_CONFIG:   data_o = CONFIG_VAL;
      default:      data_o = '0;
    endcase
  end

endmodule
